// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   NOP_INST      : canonical bubble instruction (addi x0,x0,0)
//   OPC_*         : major opcodes of the control-flow instructions
//   fetch_state_e : states of the instruction-fetch FSM
//   is_ctrl_flow  : true when an instruction may redirect the PC
package riscv_pkg;

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;

   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StHold,
      StDrop,
      StFault
   } fetch_state_e;

   function automatic logic is_ctrl_flow(input logic [31:0] inst);
      return (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR) || (inst[6:0] == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus.
//   imem_req_valid / imem_req_ready : request handshake
//   imem_req_addr                   : request address
//   imem_rsp_valid                  : single-cycle response strobe
//   imem_rsp_data                   : response instruction
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [INST_W-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer.
//   clk, rst     : clock, async active-low reset
//   flush        : kill contents (highest priority)
//   stall        : ID cannot accept; a valid entry is held
//   load_rsp     : load ld_pc / rsp_data
//   load_buf     : load ld_pc / hold buffer
//   buf_wr       : capture rsp_data into the hold buffer
//   buf_inst     : hold buffer contents
//   if_id_*      : register outputs
module if_id_reg #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INST_W   = 32,
   parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              load_rsp,
   input  logic              load_buf,
   input  logic              buf_wr,
   input  logic [ADDR_W-1:0] ld_pc,
   input  logic [INST_W-1:0] rsp_data,
   output logic [INST_W-1:0] buf_inst,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [INST_W-1:0] if_id_inst,
   output logic              if_id_valid
);

   logic [INST_W-1:0] buf_q;
   logic [ADDR_W-1:0] pc_q;
   logic [INST_W-1:0] inst_q;
   logic              valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q   <= NOP_INST;
         pc_q    <= '0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else begin
         if (buf_wr) begin
            buf_q <= rsp_data;
         end
         if (flush) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
         end else if (load_rsp || load_buf) begin
            pc_q    <= ld_pc;
            inst_q  <= load_buf ? buf_q : rsp_data;
            valid_q <= 1'b1;
         end else if (!stall) begin
            // ID consumed the entry and nothing new arrived: insert a bubble
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
         end
      end
   end

   assign buf_inst    = buf_q;
   assign if_id_pc    = pc_q;
   assign if_id_inst  = inst_q;
   assign if_id_valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one imem request at a time for the current
// PC, loads the response into IF/ID and pulses pc_write when an instruction
// enters IF/ID so the PC block can advance.
//   clk, rst            : clock, async active-low reset
//   pc                  : current PC from the PC block
//   bus (master)        : imem request/response bus
//   stall, flush        : ID back-pressure, redirect/trap kill
//   pc_write, cur_inst  : feedback to the PC block (combinational)
//   if_id_pc/inst/valid : IF/ID register
//   fetch_fault         : one-cycle response-timeout pulse
module if_fetch_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = riscv_pkg::NOP_INST,
   parameter int unsigned       MAX_WAIT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   pc,
   if_fetch_stage_if.master    bus,
   input  logic                stall,
   input  logic                flush,
   output logic                pc_write,
   output logic [INST_W-1:0]   cur_inst,
   output logic [ADDR_W-1:0]   if_id_pc,
   output logic [INST_W-1:0]   if_id_inst,
   output logic                if_id_valid,
   output logic                fetch_fault
);
   import riscv_pkg::*;

   localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] req_addr_q;
   // Set on entry to StReq: the PC block updates on the same edge, so the
   // address is taken from pc during the first request cycle.
   logic              fresh_q;
   logic [CNT_W-1:0]  wait_cnt_q;
   logic              fetch_fault_q;

   logic              handshake;
   logic              rsp_take;
   logic              accept;
   logic              load_rsp;
   logic              load_buf;
   logic              buf_wr;
   logic              timeout;
   logic [INST_W-1:0] buf_inst;

   always_comb begin
      handshake = (state_q == StReq) && bus.imem_req_ready;
      rsp_take  = (state_q == StWait) && bus.imem_rsp_valid && !flush;
      accept    = !stall || !if_id_valid;
      load_rsp  = rsp_take && accept;
      buf_wr    = rsp_take && !accept;
      load_buf  = (state_q == StHold) && !stall && !flush;
      timeout   = (wait_cnt_q == CNT_LAST) && !bus.imem_rsp_valid;
      pc_write  = load_rsp || load_buf;
      cur_inst  = NOP_INST;
      if (load_rsp) begin
         cur_inst = bus.imem_rsp_data;
      end else if (load_buf) begin
         cur_inst = buf_inst;
      end
   end

   assign bus.imem_req_valid = (state_q == StReq);
   assign bus.imem_req_addr  = fresh_q ? pc : req_addr_q;
   assign fetch_fault        = fetch_fault_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         req_addr_q    <= '0;
         fresh_q       <= 1'b0;
         wait_cnt_q    <= '0;
         fetch_fault_q <= 1'b0;
      end else begin
         fetch_fault_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               state_q    <= StReq;
               req_addr_q <= pc;
               fresh_q    <= 1'b1;
            end
            StReq: begin
               if (fresh_q) begin
                  req_addr_q <= pc;
               end
               fresh_q <= 1'b0;
               if (handshake) begin
                  wait_cnt_q <= '0;
                  state_q    <= flush ? StDrop : StWait;
               end else if (flush) begin
                  fresh_q <= 1'b1;
               end
            end
            StWait: begin
               if (flush) begin
                  if (bus.imem_rsp_valid) begin
                     state_q <= StReq;
                     fresh_q <= 1'b1;
                  end else begin
                     state_q    <= StDrop;
                     wait_cnt_q <= '0;
                  end
               end else if (bus.imem_rsp_valid) begin
                  if (accept) begin
                     state_q <= StReq;
                     fresh_q <= 1'b1;
                  end else begin
                     state_q <= StHold;
                  end
               end else if (timeout) begin
                  state_q       <= StFault;
                  fetch_fault_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StHold: begin
               if (flush || !stall) begin
                  state_q <= StReq;
                  fresh_q <= 1'b1;
               end
            end
            StDrop: begin
               // Flush is already in effect here: keep waiting for the stale response
               if (bus.imem_rsp_valid) begin
                  state_q <= StReq;
                  fresh_q <= 1'b1;
               end else if (timeout) begin
                  state_q       <= StFault;
                  fetch_fault_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StFault: begin
               if (flush) begin
                  state_q <= StReq;
                  fresh_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   if_id_reg #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .stall       (stall),
      .load_rsp    (load_rsp),
      .load_buf    (load_buf),
      .buf_wr      (buf_wr),
      .ld_pc       (req_addr_q),
      .rsp_data    (bus.imem_rsp_data),
      .buf_inst    (buf_inst),
      .if_id_pc    (if_id_pc),
      .if_id_inst  (if_id_inst),
      .if_id_valid (if_id_valid)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   localparam int unsigned MW  = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        stall;
   logic        flush;
   logic        pc_write;
   logic [31:0] cur_inst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;
   int pw_cnt = 0;
   int fault_cnt = 0;

   if_fetch_stage_if #(.ADDR_W(32), .INST_W(32)) bus ();

   if_fetch_stage #(
      .ADDR_W   (32),
      .INST_W   (32),
      .NOP_INST (NOP),
      .MAX_WAIT (MW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .bus         (bus),
      .stall       (stall),
      .flush       (flush),
      .pc_write    (pc_write),
      .cur_inst    (cur_inst),
      .if_id_pc    (if_id_pc),
      .if_id_inst  (if_id_inst),
      .if_id_valid (if_id_valid),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pc_write) pw_cnt <= pw_cnt + 1;
      if (fetch_fault) fault_cnt <= fault_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock; the bench PC model advances when pc_write was seen.
   task automatic cyc();
      logic pw;
      #1;
      pw = pc_write;
      @(posedge clk);
      #1;
      if (pw) pc = pc + 32'd4;
   endtask

   task automatic wait_req(input int max_cycles);
      int n;
      n = 0;
      while (!bus.imem_req_valid && n < max_cycles) begin
         cyc();
         n++;
      end
      check("req_seen", {31'd0, bus.imem_req_valid}, 32'd1);
   endtask

   task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
      bus.imem_req_ready = 1'b1;
      wait_req(8);
      check("req_addr", bus.imem_req_addr, exp_addr);
      cyc();
      bus.imem_req_ready = 1'b0;
      #1;
      check("one_outstanding", {31'd0, bus.imem_req_valid}, 32'd0);
      cyc();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      #1;
      check("pc_write", {31'd0, pc_write}, 32'd1);
      check("cur_inst", cur_inst, data);
      cyc();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      #1;
      check("if_id_inst", if_id_inst, data);
      check("if_id_pc", if_id_pc, exp_addr);
      check("if_id_valid", {31'd0, if_id_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int pw0;
      int f0;
      rst = 1'b0;
      pc = 32'd0;
      stall = 1'b0;
      flush = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;

      // Reset values
      @(posedge clk);
      #1;
      check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      check("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_if_id_pc", if_id_pc, 32'd0);
      check("rst_if_id_inst", if_id_inst, NOP);
      check("rst_fault", {31'd0, fetch_fault}, 32'd0);
      check("rst_pc_write", {31'd0, pc_write}, 32'd0);
      check("rst_cur_inst", cur_inst, NOP);
      rst = 1'b1;
      cyc();

      // Sequential fetches at 0, 4, 8
      pw0 = pw_cnt;
      fetch_one(32'd0, 32'h0010_0093);
      fetch_one(32'd4, 32'h0020_0113);
      fetch_one(32'd8, 32'h0030_0193);
      #1;
      check("pw_count_3", pw_cnt - pw0, 32'd3);

      // Response arrives while ID is stalled on a valid entry -> HOLD
      stall = 1'b1;
      bus.imem_req_ready = 1'b1;
      wait_req(8);
      check("hold_req_addr", bus.imem_req_addr, 32'd12);
      cyc();
      bus.imem_req_ready = 1'b0;
      cyc();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0050_0093;
      #1;
      check("hold_no_pw", {31'd0, pc_write}, 32'd0);
      check("hold_cur_nop", cur_inst, NOP);
      cyc();
      bus.imem_rsp_valid = 1'b0;
      #1;
      check("hold_keep_inst", if_id_inst, 32'h0030_0193);
      check("hold_keep_valid", {31'd0, if_id_valid}, 32'd1);
      cyc();
      #1;
      check("hold_still_no_pw", {31'd0, pc_write}, 32'd0);
      stall = 1'b0;
      #1;
      check("hold_release_pw", {31'd0, pc_write}, 32'd1);
      check("hold_release_cur", cur_inst, 32'h0050_0093);
      cyc();
      #1;
      check("hold_load_inst", if_id_inst, 32'h0050_0093);
      check("hold_load_pc", if_id_pc, 32'd12);
      check("pc_model_16", bus.imem_req_addr, 32'd16);

      // Flush in WAIT, stale response 3 cycles later
      bus.imem_req_ready = 1'b1;
      wait_req(8);
      cyc();
      bus.imem_req_ready = 1'b0;
      flush = 1'b1;
      pc = 32'h100;
      cyc();
      flush = 1'b0;
      #1;
      check("flush_valid", {31'd0, if_id_valid}, 32'd0);
      check("flush_inst", if_id_inst, NOP);
      check("drop_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      cyc();
      cyc();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      check("drop_no_pw", {31'd0, pc_write}, 32'd0);
      check("drop_cur_nop", cur_inst, NOP);
      cyc();
      bus.imem_rsp_valid = 1'b0;
      #1;
      check("drop_if_id_valid", {31'd0, if_id_valid}, 32'd0);
      check("redirect_req", {31'd0, bus.imem_req_valid}, 32'd1);
      check("redirect_addr", bus.imem_req_addr, 32'h100);

      // Flush coincident with response
      stall = 1'b1;
      fetch_one(32'h100, 32'h0070_0213);
      bus.imem_req_ready = 1'b1;
      wait_req(8);
      check("co_req_addr", bus.imem_req_addr, 32'h104);
      cyc();
      bus.imem_req_ready = 1'b0;
      cyc();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0080_0293;
      flush = 1'b1;
      pc = 32'h200;
      #1;
      check("co_no_pw", {31'd0, pc_write}, 32'd0);
      check("co_cur_nop", cur_inst, NOP);
      cyc();
      bus.imem_rsp_valid = 1'b0;
      flush = 1'b0;
      stall = 1'b0;
      #1;
      check("co_if_id_valid", {31'd0, if_id_valid}, 32'd0);
      check("co_next_addr", bus.imem_req_addr, 32'h200);

      // Response timeout
      f0 = fault_cnt;
      bus.imem_req_ready = 1'b1;
      wait_req(8);
      cyc();
      bus.imem_req_ready = 1'b0;
      n = 0;
      while (!fetch_fault && n < 4 * MW) begin
         cyc();
         n++;
      end
      check("fault_latency", n, MW);
      cyc();
      check("fault_one_pulse", {31'd0, fetch_fault}, 32'd0);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0090_0313;
      #1;
      check("fault_ignores_rsp", {31'd0, pc_write}, 32'd0);
      cyc();
      bus.imem_rsp_valid = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      check("fault_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      #1;
      check("fault_count", fault_cnt - f0, 32'd1);
      pc = 32'h300;
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      check("fault_exit_req", {31'd0, bus.imem_req_valid}, 32'd1);
      check("fault_exit_addr", bus.imem_req_addr, 32'h300);

      // Reset while in WAIT, late response after release
      bus.imem_req_ready = 1'b1;
      cyc();
      bus.imem_req_ready = 1'b0;
      cyc();
      rst = 1'b0;
      pc = 32'h400;
      #1;
      check("mid_rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      check("mid_rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
      check("mid_rst_if_id_inst", if_id_inst, NOP);
      check("mid_rst_if_id_pc", if_id_pc, 32'd0);
      cyc();
      cyc();
      rst = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h00A0_0393;
      #1;
      check("late_rsp_no_pw", {31'd0, pc_write}, 32'd0);
      check("late_rsp_cur", cur_inst, NOP);
      cyc();
      #1;
      check("late_rsp_no_pw2", {31'd0, pc_write}, 32'd0);
      bus.imem_rsp_valid = 1'b0;
      check("post_rst_req", {31'd0, bus.imem_req_valid}, 32'd1);
      check("post_rst_addr", bus.imem_req_addr, 32'h400);
      cyc();
      check("post_rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
